// File: rtl/seven_seg_pkg.sv
// ---------------------------------------------------------------------------
// seven_seg_pkg : glyph constants, ASCII codes and capture FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package seven_seg_pkg;

  // Segment order a..g from left to right; a 0 lights the segment.
  typedef logic [0:6] glyph_t;

  localparam glyph_t GLYPH_0     = 7'b0000001;
  localparam glyph_t GLYPH_1     = 7'b1001111;
  localparam glyph_t GLYPH_2     = 7'b0010010;
  localparam glyph_t GLYPH_3     = 7'b0000110;
  localparam glyph_t GLYPH_4     = 7'b1001100;
  localparam glyph_t GLYPH_5     = 7'b0100100;
  localparam glyph_t GLYPH_6     = 7'b0100000;
  localparam glyph_t GLYPH_7     = 7'b0001111;
  localparam glyph_t GLYPH_8     = 7'b0000000;
  localparam glyph_t GLYPH_9     = 7'b0000100;
  localparam glyph_t GLYPH_A     = 7'b0001000;
  localparam glyph_t GLYPH_B_LO  = 7'b1100000;
  localparam glyph_t GLYPH_C     = 7'b0110001;
  localparam glyph_t GLYPH_D_LO  = 7'b1000010;
  localparam glyph_t GLYPH_E     = 7'b0110000;
  localparam glyph_t GLYPH_F     = 7'b0111000;
  localparam glyph_t GLYPH_H     = 7'b1001000;
  localparam glyph_t GLYPH_H_LO  = 7'b1101000;
  localparam glyph_t GLYPH_J     = 7'b1000011;
  localparam glyph_t GLYPH_L     = 7'b1110001;
  localparam glyph_t GLYPH_N_LO  = 7'b1101010;
  localparam glyph_t GLYPH_O_LO  = 7'b1100010;
  localparam glyph_t GLYPH_P     = 7'b0011000;
  localparam glyph_t GLYPH_R_LO  = 7'b1111010;
  localparam glyph_t GLYPH_T_LO  = 7'b1110000;
  localparam glyph_t GLYPH_U     = 7'b1000001;
  localparam glyph_t GLYPH_DASH  = 7'b1111110;
  localparam glyph_t GLYPH_BLANK = 7'b1111111;
  localparam glyph_t GLYPH_L_LO  = 7'b1110011;
  // Look-alikes share a pattern with a digit and therefore decode as that digit.
  localparam glyph_t GLYPH_O     = GLYPH_0;
  localparam glyph_t GLYPH_S     = GLYPH_5;

  localparam logic [7:0] ASCII_BLANK   = 8'h20;
  localparam logic [7:0] ASCII_UNKNOWN = 8'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } cap_state_e;

endpackage

`default_nettype wire

// File: rtl/seg7_glyph_to_ascii.sv
// ---------------------------------------------------------------------------
// seg7_glyph_to_ascii : combinational active-low 7-segment glyph to ASCII
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seg7_glyph_to_ascii
  import seven_seg_pkg::*;
(
  input  logic [0:6] seg_i,
  output logic [7:0] ascii_o,
  output logic       known_o
);

  always_comb begin
    ascii_o = ASCII_UNKNOWN;
    known_o = 1'b1;
    case (seg_i)
      GLYPH_0:     ascii_o = 8'h30;
      GLYPH_1:     ascii_o = 8'h31;
      GLYPH_2:     ascii_o = 8'h32;
      GLYPH_3:     ascii_o = 8'h33;
      GLYPH_4:     ascii_o = 8'h34;
      GLYPH_5:     ascii_o = 8'h35;
      GLYPH_6:     ascii_o = 8'h36;
      GLYPH_7:     ascii_o = 8'h37;
      GLYPH_8:     ascii_o = 8'h38;
      GLYPH_9:     ascii_o = 8'h39;
      GLYPH_A:     ascii_o = 8'h41;
      GLYPH_B_LO:  ascii_o = 8'h62;
      GLYPH_C:     ascii_o = 8'h43;
      GLYPH_D_LO:  ascii_o = 8'h64;
      GLYPH_E:     ascii_o = 8'h45;
      GLYPH_F:     ascii_o = 8'h46;
      GLYPH_H:     ascii_o = 8'h48;
      GLYPH_H_LO:  ascii_o = 8'h68;
      GLYPH_J:     ascii_o = 8'h4A;
      GLYPH_L:     ascii_o = 8'h4C;
      GLYPH_N_LO:  ascii_o = 8'h6E;
      GLYPH_O_LO:  ascii_o = 8'h6F;
      GLYPH_P:     ascii_o = 8'h50;
      GLYPH_R_LO:  ascii_o = 8'h72;
      GLYPH_T_LO:  ascii_o = 8'h74;
      GLYPH_U:     ascii_o = 8'h55;
      GLYPH_DASH:  ascii_o = 8'h2D;
      GLYPH_BLANK: ascii_o = ASCII_BLANK;
      GLYPH_L_LO:  ascii_o = 8'h31;
      default: begin
        ascii_o = ASCII_UNKNOWN;
        known_o = 1'b0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seven_seg_ascii_capture.sv
// ---------------------------------------------------------------------------
// seven_seg_ascii_capture : rebuilds packed ASCII text from scanned seg/an lines
// Optional left-scroll detector: define SEG_CAPTURE_SCROLL_DETECT_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module seven_seg_ascii_capture
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int CNT_W         = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [0:6]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [8*NUM_DIGITS-1:0] packedAscii,
  output logic [NUM_DIGITS-1:0]   digitValid,
  output logic                    frameValid,
  output logic                    frameChanged,
  output logic                    unknownGlyph,
  output logic                    scrollStep
);

  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  // Assertion is immediate; release is retimed onto clk.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_n = rst_sync_q[1];

  cap_state_e                       state_q, state_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d, cnt_inc;
  logic [NUM_DIGITS-1:0]            an_prev_q;
  logic [0:6]                       seg_prev_q;
  logic                             sample;
  logic                             an_valid, an_chg, seg_chg;

  logic [NUM_DIGITS-1:0][7:0]       wbuf_q, wbuf_d;
  logic [NUM_DIGITS-1:0][7:0]       packed_q, packed_d;
  logic [NUM_DIGITS-1:0]            dvalid_q, dvalid_d;
  logic [NUM_DIGITS-1:0]            unk_q, unk_d;
  logic                             fv_q, fv_d, fc_q, fc_d, ug_q, ug_d;
  logic                             complete;

  logic [7:0]                       dec_ascii;
  logic                             dec_known;

  seg7_glyph_to_ascii u_dec (
    .seg_i   (seg),
    .ascii_o (dec_ascii),
    .known_o (dec_known)
  );

  assign an_valid = $onehot(~an);
  assign an_chg   = (an != an_prev_q);
  assign seg_chg  = (seg != seg_prev_q);
  assign cnt_inc  = cnt_q + 1'b1;
  assign complete = (dvalid_q == {NUM_DIGITS{1'b1}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      an_prev_q  <= '1;
      seg_prev_q <= '1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      an_prev_q  <= an;
      seg_prev_q <= seg;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sample  = 1'b0;
    if (!an_valid) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = SETTLE;
          cnt_d   = '0;
        end
        SETTLE: begin
          if (an_chg || seg_chg) begin
            cnt_d = '0;
          end else if (cnt_inc == STABLE_LAST) begin
            state_d = HOLD;
            cnt_d   = '0;
            sample  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        HOLD: begin
          // Segment changes on a held digit are ignored until the anode moves.
          if (an_chg) begin
            state_d = SETTLE;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // A sample landing on the completion edge opens the next frame.
  always_comb begin
    wbuf_d   = wbuf_q;
    packed_d = packed_q;
    dvalid_d = complete ? '0 : dvalid_q;
    unk_d    = complete ? '0 : unk_q;
    fv_d     = complete;
    fc_d     = complete && (wbuf_q != packed_q);
    ug_d     = complete ? (|unk_q) : ug_q;
    if (complete) packed_d = wbuf_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (sample && !an[i]) begin
        wbuf_d[i]   = dec_ascii;
        dvalid_d[i] = 1'b1;
        unk_d[i]    = ~dec_known;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbuf_q   <= {NUM_DIGITS{ASCII_BLANK}};
      packed_q <= {NUM_DIGITS{ASCII_BLANK}};
      dvalid_q <= '0;
      unk_q    <= '0;
      fv_q     <= 1'b0;
      fc_q     <= 1'b0;
      ug_q     <= 1'b0;
    end else begin
      wbuf_q   <= wbuf_d;
      packed_q <= packed_d;
      dvalid_q <= dvalid_d;
      unk_q    <= unk_d;
      fv_q     <= fv_d;
      fc_q     <= fc_d;
      ug_q     <= ug_d;
    end
  end

`ifdef SEG_CAPTURE_SCROLL_DETECT_EN
  logic scroll_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) scroll_q <= 1'b0;
    else        scroll_q <= complete && (wbuf_q != packed_q) &&
                            (wbuf_q[NUM_DIGITS-1:1] == packed_q[NUM_DIGITS-2:0]);
  end

  assign scrollStep = scroll_q;
`else
  assign scrollStep = 1'b0;
`endif

  assign packedAscii  = packed_q;
  assign digitValid   = dvalid_q;
  assign frameValid   = fv_q;
  assign frameChanged = fc_q;
  assign unknownGlyph = ug_q;

endmodule

`default_nettype wire

// File: doc/seven_seg_ascii_capture.md
Name: seven_seg_ascii_capture

Overview:
- Receive-side counterpart of the multiplexed 4-digit 7-segment ASCII display driver.
- Watches the scanned seg/an lines and reconstructs the four displayed characters as packed ASCII.
- Flags each completed scan frame and reports when the displayed text has changed.
- Used for loopback self-check on the board and as a bench monitor for display/scroll blocks.

Parameters:
- NUM_DIGITS, 4, number of anode positions scanned.
- STABLE_CYCLES, 16, consecutive unchanged clk cycles required before a digit is sampled.
- CNT_W, 8, stability counter width; must satisfy 2**CNT_W > STABLE_CYCLES.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- seg  in  [0:6]  segment lines, active-low; seg[0]=a … seg[6]=g.
- an  in  [3:0]  anode lines, active-low one-hot; an[3] = leftmost digit.
- packedAscii  out  [31:0]  last complete frame; an[3] maps to bits 31:24, an[0] to bits 7:0.
- digitValid  out  [3:0]  slots captured in the current, incomplete frame.
- frameValid  out  1  one-cycle pulse when packedAscii updates.
- frameChanged  out  1  one-cycle pulse, coincident with frameValid, when the new frame differs from the previous one.
- unknownGlyph  out  1  some slot in the last frame held an undecodable pattern.
- scrollStep  out  1  see Optional Feature.

Behaviour:
- Reset (async assert, sync-safe deassert) sets:
  - packedAscii = 0x20202020.
  - digitValid = 0.
  - All pulses = 0, unknownGlyph = 0, FSM = IDLE, counter = 0.
- The anode pattern is valid only when exactly one bit of an is 0. Any other pattern (all-high, multi-low) forces IDLE and clears the counter.
- FSM:
  - IDLE: on a valid an, go to SETTLE with counter = 0.
  - SETTLE: counter increments each cycle while an and seg are unchanged from the previous cycle. Any change restarts the counter at 0, and goes to IDLE if an has become invalid. When the counter reaches STABLE_CYCLES-1, go to HOLD and sample on that edge.
  - HOLD: the digit has been captured. Stay here with no resampling until an changes, then go to SETTLE (valid an) or IDLE (invalid an).
- Sample action:
  - Decode seg to ASCII and write it into the slot selected by the active anode.
  - Set the corresponding digitValid bit.
  - Resampling a slot already valid in the same frame overwrites it silently.
- Decode table:
  - Digits 0–9 decode to 0x30–0x39.
  - Letters A b C d E F H h J L n o P r t U decode to their ASCII codes, upper/lower case as displayed.
  - Dash decodes to 0x2D; all segments off decodes to 0x20.
  - Ambiguous glyphs resolve to the digit: l→'1', O→'0', S→'5'.
  - Any other pattern decodes to 0x3F ('?') and marks the frame unknown.
- Frame completion: the cycle after the sample that makes digitValid = 4'hF:
  - packedAscii is loaded from the working buffer.
  - frameValid = 1.
  - frameChanged = (new != previous packedAscii).
  - unknownGlyph is updated from the sticky flag.
  - digitValid and the sticky flag clear.
- Latency: digit sample at STABLE_CYCLES cycles after an/seg settle; frame outputs one cycle after the last sample.
- A slot sampled on the completion edge itself belongs to the next frame.
- Reset mid-frame discards the partial frame.

Optional Feature:
- Macro SEG_CAPTURE_SCROLL_DETECT_EN.
- Defined:
  - scrollStep pulses with frameValid when new[31:8] == previous packedAscii[23:0] and the frames differ, i.e. a left shift by one character.
  - Adds a 24-bit comparator.
- Undefined: scrollStep is tied to 0 and no comparator logic is built.

Decomposition:
- Package seven_seg_pkg holds:
  - Active-low glyph constants GLYPH_0…GLYPH_9, GLYPH_A, GLYPH_BLANK, GLYPH_DASH, etc.
  - ASCII_BLANK = 8'h20 and ASCII_UNKNOWN = 8'h3F.
  - FSM state encodings IDLE, SETTLE, HOLD.
- Sub-module seg7_glyph_to_ascii: a purely combinational decoder, 7-bit seg in, 8-bit ASCII plus known flag out. It is shared with future keypad/echo blocks.

Test Plan:
1. Hold reset low for 5 cycles with random seg/an → packedAscii = 0x20202020, digitValid = 0, no pulses.
2. Scan "1005", 20 cycles per digit:
   - an = 0111 with seg 1001111, an = 1011 with seg 0000001, an = 1101 with seg 0000001, an = 1110 with seg 0100100.
   - Expect one frameValid, packedAscii = 0x31303035, frameChanged = 1.
3. Repeat the identical scan → frameValid = 1, frameChanged = 0.
4. Invalid-input filtering:
   - an = 0101 for 30 cycles → no sample.
   - Valid an with seg toggled at cycle 8 → sample occurs 16 cycles after the toggle, not before.
5. Undecodable and async-reset cases:
   - seg = 1010101 in slot an[1] → packedAscii[15:8] = 0x3F, unknownGlyph = 1.
   - Async reset mid-scan → digitValid = 0 immediately.
6. With SEG_CAPTURE_SCROLL_DETECT_EN defined:
   - Frame 0x31303035 followed by 0x30303520 → scrollStep = 1 with frameValid.
   - Without the macro → scrollStep stays 0.
